// File: rtl/prim_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial stage.
// Optional parity bit is enabled with `define PRIM_SERIALIZER_PARITY_EN.
package prim_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } prim_ser_st_e;

  // Bit counter width: enough to index every bit of a word.
  function automatic int ser_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/prim_serializer.sv
// Parallel-to-serial stage: loads a WIDTH-bit word on valid/ready and emits one bit per en_i tick.
// Define PRIM_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
//
// Handshake: a word transfers on any posedge where valid_i & ready_o; ready_o is high in IDLE
// and, combinationally, on the final bit of a frame, so a held valid_i loads back-to-back.
module prim_serializer
  import prim_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             serial_o,
  output logic             shift_en_o,
  output logic             busy_o,
  output logic             done_o,
  output prim_ser_st_e     st_o
);

  localparam int CW = ser_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  prim_ser_st_e     st_q, st_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;
  logic             load;
`ifdef PRIM_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign st_o = st_q;

  // Shift toward the output end, zero-filling the vacated bit.
  always_comb begin
    if (LSB_FIRST) begin
      out_bit       = shreg_q[0];
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin
      out_bit       = shreg_q[WIDTH-1];
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    st_d       = st_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    ready_o    = 1'b0;
    serial_o   = IDLE_LEVEL;
    shift_en_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    load       = 1'b0;
`ifdef PRIM_SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif
    case (st_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        load    = valid_i;
      end
      ST_SHIFT: begin
        serial_o   = out_bit;
        busy_o     = 1'b1;
        shift_en_o = en_i;
        if (en_i) begin
          shreg_d = shreg_shifted;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef PRIM_SERIALIZER_PARITY_EN
            st_d = ST_PARITY;
`else
            done_o  = 1'b1;
            ready_o = 1'b1;
            load    = valid_i;
            if (!valid_i) st_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef PRIM_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        serial_o   = par_q;
        busy_o     = 1'b1;
        shift_en_o = en_i;
        if (en_i) begin
          done_o  = 1'b1;
          ready_o = 1'b1;
          load    = valid_i;
          if (!valid_i) st_d = ST_IDLE;
        end
      end
`endif
      default: st_d = ST_IDLE;
    endcase

    // A load overrides any shift decided above, including on the last bit.
    if (load) begin
      shreg_d = data_i;
      cnt_d   = '0;
      st_d    = ST_SHIFT;
`ifdef PRIM_SERIALIZER_PARITY_EN
      par_d   = ^data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PRIM_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PRIM_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
